// File: rtl/bram_delay_line_ctrl.sv
// Circular delay-line controller for a single-port, read-before-write, negedge BRAM.
// Each accepted sample is written at ptr while the word stored len samples earlier is read back.
module bram_delay_line_ctrl #(
    parameter int N = 9,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [N-1:0] cfg_delay,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic [N-1:0] bram_addr,
    output logic         bram_read_write,
    output logic         bram_clear,
    output logic [W-1:0] bram_data_in,
    input  logic [W-1:0] bram_data_out
);

    // Handshakes: a sample moves on a posedge where valid & ready are both high;
    // valid never depends on ready, and out_data is held while out_valid & !out_ready.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] ptr_q, ptr_d;
    logic [N-1:0] len_q, len_d;
    logic         load_len_q, load_len_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [N-1:0] len_eff;
    logic [N-1:0] last_ptr;
    logic         accept;

    // cfg_delay is taken on the first cycle after reset release; len=0 makes
    // last_ptr all-ones so the pointer wraps naturally at 2**N.
    assign len_eff  = load_len_q ? cfg_delay : len_q;
    assign last_ptr = len_eff - ONE;

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        len_d           = len_eff;
        load_len_d      = 1'b0;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        in_ready        = 1'b0;
        accept          = 1'b0;
        bram_addr       = ptr_q;
        bram_read_write = 1'b0;
        bram_data_in    = '0;
        case (state_q)
            ST_INIT: begin
                // Gated by rst_n so nothing is written while reset is held.
                bram_read_write = rst_n;
                if (flush) begin
                    ptr_d = '0;
                    len_d = cfg_delay;
                end else if (ptr_q == last_ptr) begin
                    ptr_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + ONE;
                end
            end
            ST_RUN: begin
                in_ready        = !flush && (!out_valid_q || out_ready);
                accept          = in_valid && in_ready;
                bram_data_in    = in_data;
                bram_read_write = accept && rst_n;
                if (flush) begin
                    state_d     = ST_INIT;
                    ptr_d       = '0;
                    len_d       = cfg_delay;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    out_data_d  = bram_data_out;
                    out_valid_d = 1'b1;
                    ptr_d       = (ptr_q == last_ptr) ? '0 : ptr_q + ONE;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            len_q       <= '0;
            load_len_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            load_len_q  <= load_len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q == ST_INIT);
    assign bram_clear = 1'b0;

endmodule

// File: tb/tb_bram_delay_line_ctrl.sv
// Bench for bram_delay_line_ctrl: behavioural negedge BRAM plus a queue-based delay-line model.
module tb_bram_delay_line_ctrl;
    localparam int N = 9;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [N-1:0] cfg_delay;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic [N-1:0] bram_addr;
    logic         bram_rw;
    logic         bram_clear;
    logic [W-1:0] bram_din;
    logic [W-1:0] bram_dout;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] dl_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] mem [0:(1<<N)-1];

    bram_delay_line_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_delay(cfg_delay),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .bram_addr(bram_addr), .bram_read_write(bram_rw),
        .bram_clear(bram_clear), .bram_data_in(bram_din), .bram_data_out(bram_dout)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port read-before-write memory clocked on the falling edge.
    always @(negedge clk) begin
        bram_dout <= mem[bram_addr];
        if (bram_rw) mem[bram_addr] <= bram_din;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Delay line of len entries, all zero after INIT.
    task automatic model_init(input logic [N-1:0] cfg);
        int n;
        n = (cfg == 0) ? (1 << N) : int'(cfg);
        dl_q.delete();
        exp_q.delete();
        repeat (n) dl_q.push_back('0);
    endtask

    // scoreboard / protocol monitor
    bit           prev_acc;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy) begin
                check_eq("rdy_init", 32'(in_ready), 32'd0);
                check_eq("ov_init", 32'(out_valid), 32'd0);
            end else begin
                check_eq("rdy", 32'(in_ready), 32'(!flush && (!out_valid || out_ready)));
            end
            if (prev_acc) check_eq("lat", 32'(out_valid), 32'd1);
            if (prev_stall) check_eq("hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("extra_out", 32'd1, 32'd0);
                else check_eq("out", 32'(out_data), 32'(exp_q.pop_front()));
                obs_q.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(dl_q.pop_front());
                dl_q.push_back(in_data);
            end
            if (flush) model_init(cfg_delay);
            prev_acc   = in_valid && in_ready;
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
        end
    end

    // driver tasks
    task automatic count_busy(input int exp_len);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 1100 && !done; g++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1'b1;
        end
        check_eq("busy_len", 32'(n), 32'(exp_len));
    endtask

    task automatic do_reset(input logic [N-1:0] cfg);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ov", 32'(out_valid), 32'd0);
        check_eq("rst_rw", 32'(bram_rw), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_od", 32'(out_data), 32'd0);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cfg_delay = cfg;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init(cfg);
        obs_q.delete();
        count_busy((cfg == 0) ? (1 << N) : int'(cfg));
    endtask

    task automatic send(input int n, input bit rnd, input int base, input int vpct, input int rpct);
        int i;
        int guard;
        bit held;
        i     = 0;
        guard = 0;
        held  = 1'b0;
        while (i < n && guard < 20000) begin
            @(posedge clk);
            #1;
            if (!held) begin
                in_valid = ($urandom_range(1, 100) <= vpct);
                if (in_valid) begin
                    held    = 1'b1;
                    in_data = rnd ? W'($urandom_range(0, 65535)) : W'(base + i);
                end
            end
            out_ready = ($urandom_range(1, 100) <= rpct);
            @(negedge clk);
            if (in_valid && in_ready) begin
                i++;
                held = 1'b0;
            end
            guard++;
        end
        check_eq("send_count", 32'(i), 32'(n));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush(input logic [N-1:0] cfg);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        cfg_delay = cfg;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_ov", 32'(out_valid), 32'd0);
        count_busy((cfg == 0) ? (1 << N) : int'(cfg));
        obs_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        cfg_delay = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int a = 0; a < (1 << N); a++) mem[a] = W'($urandom_range(1, 65535));

        // delay 4, ramp 1..10
        do_reset(9'd4);
        send(10, 1'b0, 1, 100, 100);
        drain();
        check_eq("t1_n", 32'(obs_q.size()), 32'd10);
        for (int k = 0; k < 10 && k < obs_q.size(); k++)
            check_eq("t1_out", 32'(obs_q[k]), (k < 4) ? 32'd0 : 32'(k - 3));

        // full-depth delay, pointer wrap
        do_reset(9'd0);
        send(1000, 1'b0, 0, 100, 100);
        drain();
        check_eq("t2_n", 32'(obs_q.size()), 32'd1000);
        if (obs_q.size() == 1000) begin
            check_eq("t2_511", 32'(obs_q[511]), 32'd0);
            check_eq("t2_513", 32'(obs_q[513]), 32'd1);
            check_eq("t2_999", 32'(obs_q[999]), 32'd487);
        end

        // random gaps and back-pressure; cfg change in RUN is ignored
        do_reset(9'd3);
        cfg_delay = 9'd9;
        send(300, 1'b1, 0, 70, 50);
        drain();

        // flush mid-stream with a new delay
        do_reset(9'd5);
        send(10, 1'b0, 100, 100, 100);
        do_flush(9'd2);
        send(10, 1'b0, 200, 100, 100);
        drain();
        check_eq("t4_n", 32'(obs_q.size()), 32'd10);
        if (obs_q.size() == 10) begin
            check_eq("t4_0", 32'(obs_q[0]), 32'd0);
            check_eq("t4_1", 32'(obs_q[1]), 32'd0);
            check_eq("t4_2", 32'(obs_q[2]), 32'd200);
            check_eq("t4_9", 32'(obs_q[9]), 32'd207);
        end

        // asynchronous reset between edges while RUN is active
        do_reset(9'd6);
        send(20, 1'b1, 0, 100, 100);
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b0;
        check_eq("pre_rst_ov", 32'(out_valid), 32'd1);
        do_reset(9'd3);
        send(10, 1'b1, 0, 80, 80);
        drain();

        // delay 1: 7,8,9 -> 0,7,8
        do_reset(9'd1);
        send(3, 1'b0, 7, 100, 100);
        drain();
        check_eq("t6_n", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            check_eq("t6_0", 32'(obs_q[0]), 32'd0);
            check_eq("t6_1", 32'(obs_q[1]), 32'd7);
            check_eq("t6_2", 32'(obs_q[2]), 32'd8);
        end
        check_eq("clear_tied", 32'(bram_clear), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
